// File: rtl/hazard_pkg.sv
// Shared constants and compare helpers for the pipeline hazard controller.
package hazard_pkg;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   localparam int DEFAULT_MULT_CYCLES = 4;
   localparam int DEFAULT_DIV_CYCLES  = 32;
   localparam int MD_CNT_W            = 6;

   // A writer only matters when it is enabled and not targeting $zero.
   function automatic logic reg_match(input logic we, input logic [4:0] rd, input logic [4:0] src);
      reg_match = we && (rd != 5'd0) && (rd == src);
   endfunction

   // Youngest producer wins: EX/MEM before MEM/WB.
   function automatic logic [1:0] fwd_select(input logic       mem_we,
                                             input logic [4:0] mem_rd,
                                             input logic       wb_we,
                                             input logic [4:0] wb_rd,
                                             input logic [4:0] src);
      if (reg_match(mem_we, mem_rd, src)) begin
         fwd_select = FWD_EXMEM;
      end else if (reg_match(wb_we, wb_rd, src)) begin
         fwd_select = FWD_MEMWB;
      end else begin
         fwd_select = FWD_REG;
      end
   endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_counter.sv
// Multiply/divide occupancy counter; busy is decoded from the counter register only.
module md_busy_counter
   import hazard_pkg::*;
#(
   parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
)(
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic div,
   output logic busy
);

   localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
   localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);

   logic [MD_CNT_W-1:0] count_r;

   // Load on an idle start, count down to zero; starts while busy are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= {MD_CNT_W{1'b0}};
      end else if (start && (count_r == {MD_CNT_W{1'b0}})) begin
         count_r <= div ? DIV_LOAD : MULT_LOAD;
      end else if (count_r != {MD_CNT_W{1'b0}}) begin
         count_r <= count_r - {{(MD_CNT_W-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign busy = (count_r != {MD_CNT_W{1'b0}});

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline forwarding and stall control. Define HAZARD_FORWARDING_EN for bypassing;
// without it operands always come from the regfile and RAW hazards stall instead.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic [4:0] ex_rs,
   input  logic [4:0] ex_rt,
   input  logic [4:0] ex_rd,
   input  logic       ex_reg_write,
   input  logic       ex_mem_read,
   input  logic [4:0] mem_rd,
   input  logic       mem_reg_write,
   input  logic [4:0] wb_rd,
   input  logic       wb_reg_write,
   input  logic       ex_md_start,
   input  logic       ex_md_div,
   input  logic       id_md_use,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b,
   output logic       stall_if,
   output logic       stall_id,
   output logic       flush_ex,
   output logic       md_busy
);

   logic md_busy_s;
   logic load_use_stall_s;
   logic md_stall_s;
   logic raw_stall_s;
   logic stall_s;

   md_busy_counter #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_md_busy_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .start (ex_md_start),
      .div   (ex_md_div),
      .busy  (md_busy_s)
   );

   // Load-use and mult/div occupancy stalls exist in every build.
   always_comb begin
      load_use_stall_s = 1'b0;
      md_stall_s       = 1'b0;
      if (ex_mem_read && (ex_rd != 5'd0) && ((ex_rd == id_rs) || (ex_rd == id_rt))) begin
         load_use_stall_s = 1'b1;
      end else begin
         load_use_stall_s = 1'b0;
      end
      md_stall_s = id_md_use && md_busy_s;
   end

`ifdef HAZARD_FORWARDING_EN
   logic unused_fwd_s;
   assign unused_fwd_s = ex_reg_write;

   // Bypass muxes cover RAW hazards, so no extra stall is needed.
   always_comb begin
      fwd_a       = fwd_select(mem_reg_write, mem_rd, wb_reg_write, wb_rd, ex_rs);
      fwd_b       = fwd_select(mem_reg_write, mem_rd, wb_reg_write, wb_rd, ex_rt);
      raw_stall_s = 1'b0;
   end
`else
   logic unused_fwd_s;
   assign unused_fwd_s = ^{ex_rs, ex_rt, wb_rd, wb_reg_write};

   // WB needs no check: the regfile writes before it is read.
   always_comb begin
      fwd_a       = FWD_REG;
      fwd_b       = FWD_REG;
      raw_stall_s = reg_match(ex_reg_write, ex_rd, id_rs)   ||
                    reg_match(ex_reg_write, ex_rd, id_rt)   ||
                    reg_match(mem_reg_write, mem_rd, id_rs) ||
                    reg_match(mem_reg_write, mem_rd, id_rt);
   end
`endif

   assign stall_s  = load_use_stall_s || md_stall_s || raw_stall_s;
   assign stall_if = stall_s;
   assign stall_id = stall_s;
   assign flush_ex = stall_s;
   assign md_busy  = md_busy_s;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (either HAZARD_FORWARDING_EN build).
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
   logic       ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write;
   logic       ex_md_start, ex_md_div, id_md_use;
   logic [1:0] fwd_a, fwd_b;
   logic       stall_if, stall_id, flush_ex, md_busy;

   int tests_run = 0;
   int tests_failed = 0;
   int cnt;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .ex_rs         (ex_rs),
      .ex_rt         (ex_rt),
      .ex_rd         (ex_rd),
      .ex_reg_write  (ex_reg_write),
      .ex_mem_read   (ex_mem_read),
      .mem_rd        (mem_rd),
      .mem_reg_write (mem_reg_write),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .ex_md_start   (ex_md_start),
      .ex_md_div     (ex_md_div),
      .id_md_use     (id_md_use),
      .fwd_a         (fwd_a),
      .fwd_b         (fwd_b),
      .stall_if      (stall_if),
      .stall_id      (stall_id),
      .flush_ex      (flush_ex),
      .md_busy       (md_busy)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      id_rs = 5'd0; id_rt = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0;
      mem_rd = 5'd0; wb_rd = 5'd0;
      ex_reg_write = 1'b0; ex_mem_read = 1'b0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
      ex_md_start = 1'b0; ex_md_div = 1'b0; id_md_use = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns {stall_if, stall_id, flush_ex} packed for one-shot comparison.
   function automatic logic [2:0] stalls();
      stalls = {stall_if, stall_id, flush_ex};
   endfunction

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      #2;
      check_val("reset_busy", 32'(md_busy), 32'd0);
      check_val("reset_stall", 32'(stalls()), 32'd0);
      check_val("reset_fwd", 32'({fwd_a, fwd_b}), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check_val("idle_busy", 32'(md_busy), 32'd0);
      check_val("idle_stall", 32'(stalls()), 32'd0);
      check_val("idle_fwd", 32'({fwd_a, fwd_b}), 32'd0);

      // Forwarding priority vectors
      mem_reg_write = 1'b1; mem_rd = 5'd5; wb_reg_write = 1'b1; wb_rd = 5'd5;
      ex_rs = 5'd5; ex_rt = 5'd5;
      #1;
`ifdef HAZARD_FORWARDING_EN
      check_val("fwd_a_exmem", 32'(fwd_a), 32'd1);
      check_val("fwd_b_exmem", 32'(fwd_b), 32'd1);
`else
      check_val("fwd_a_off", 32'(fwd_a), 32'd0);
      check_val("fwd_b_off", 32'(fwd_b), 32'd0);
`endif
      check_val("fwd_no_stall", 32'(stalls()), 32'd0);
      mem_reg_write = 1'b0;
      #1;
`ifdef HAZARD_FORWARDING_EN
      check_val("fwd_a_memwb", 32'(fwd_a), 32'd2);
`else
      check_val("fwd_a_memwb_off", 32'(fwd_a), 32'd0);
`endif
      mem_reg_write = 1'b1; mem_rd = 5'd0; ex_rt = 5'd9;
      #1;
`ifdef HAZARD_FORWARDING_EN
      check_val("fwd_a_rd0_skip", 32'(fwd_a), 32'd2);
      check_val("fwd_b_nomatch", 32'(fwd_b), 32'd0);
`else
      check_val("fwd_b_nomatch_off", 32'(fwd_b), 32'd0);
`endif
      ex_rs = 5'd0; wb_rd = 5'd0;
      #1;
      check_val("fwd_a_zero", 32'(fwd_a), 32'd0);
      clear_inputs();

      // Load-use stall
      ex_mem_read = 1'b1; ex_rd = 5'd8; id_rt = 5'd8;
      #1;
      check_val("loaduse_rt", 32'(stalls()), 32'd7);
      id_rt = 5'd0; id_rs = 5'd8;
      #1;
      check_val("loaduse_rs", 32'(stalls()), 32'd7);
      ex_rd = 5'd0; id_rs = 5'd0;
      #1;
      check_val("loaduse_rd0", 32'(stalls()), 32'd0);
      ex_mem_read = 1'b0; ex_rd = 5'd8; id_rt = 5'd8;
      #1;
      check_val("loaduse_noload", 32'(stalls()), 32'd0);
      clear_inputs();

      // RAW stall without forwarding
      ex_reg_write = 1'b1; ex_rd = 5'd3; id_rs = 5'd3;
      #1;
`ifdef HAZARD_FORWARDING_EN
      check_val("raw_fwd_build", 32'(stalls()), 32'd0);
`else
      check_val("raw_ex", 32'(stalls()), 32'd7);
      check_val("raw_ex_fwd", 32'({fwd_a, fwd_b}), 32'd0);
      clear_inputs();
      mem_reg_write = 1'b1; mem_rd = 5'd7; id_rt = 5'd7;
      #1;
      check_val("raw_mem", 32'(stalls()), 32'd7);
      mem_rd = 5'd0; id_rt = 5'd0;
      #1;
      check_val("raw_zero", 32'(stalls()), 32'd0);
`endif
      clear_inputs();
      tick();

      // Multiply: 4 busy cycles, stall while ID wants HI/LO
      ex_md_start = 1'b1; ex_md_div = 1'b0; id_md_use = 1'b1;
      #1;
      check_val("mult_prestart_busy", 32'(md_busy), 32'd0);
      check_val("mult_prestart_stall", 32'(stalls()), 32'd0);
      tick();
      ex_md_start = 1'b0;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) check_val("mult_cnt1_stall", 32'(stall_if), 32'd1);
         if (i == 4) check_val("mult_done_busy", 32'(md_busy), 32'd0);
         if (stall_if) cnt++;
         tick();
      end
      check_val("mult_stall_cycles", 32'(cnt), 32'd4);
      clear_inputs();

      // Divide with an ignored restart
      ex_md_start = 1'b1; ex_md_div = 1'b1;
      tick();
      ex_md_start = 1'b0;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (md_busy) cnt++;
         if (i == 2) ex_md_start = 1'b1;
         if (i == 3) ex_md_start = 1'b0;
         tick();
      end
      check_val("div_busy_cycles", 32'(cnt), 32'd32);
      clear_inputs();

      // Reset mid-division
      ex_md_start = 1'b1; ex_md_div = 1'b1;
      tick();
      ex_md_start = 1'b0;
      repeat (10) tick();
      check_val("div_busy_pre_reset", 32'(md_busy), 32'd1);
      id_md_use = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check_val("reset_mid_busy", 32'(md_busy), 32'd0);
      check_val("reset_mid_stall", 32'(stalls()), 32'd0);
      #2;
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (md_busy || stall_if) cnt++;
      end
      check_val("post_reset_idle", 32'(cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: MULT_CYCLES, default 4, multiply occupancy in cycles (1..63).
REQ-002 Parameter: DIV_CYCLES, default 32, divide occupancy in cycles (1..63).
REQ-003 Port: clk  in  1  single clock, rising edge.
REQ-004 Port: rst_n  in  1  asynchronous active-low reset.
REQ-005 Port: id_rs, id_rt  in  5 each  ID-stage source registers.
REQ-006 Port: ex_rs, ex_rt  in  5 each  EX-stage source registers.
REQ-007 Port: ex_rd, ex_reg_write, ex_mem_read  in  5/1/1  EX destination, write enable, load flag.
REQ-008 Port: mem_rd, mem_reg_write  in  5/1  EX/MEM destination and write enable.
REQ-009 Port: wb_rd, wb_reg_write  in  5/1  MEM/WB destination and write enable.
REQ-010 Port: ex_md_start, ex_md_div  in  1/1  EX issues mult/div (div=1 selects divide).
REQ-011 Port: id_md_use  in  1  ID instruction reads HI/LO or starts mult/div.
REQ-012 Port: fwd_a, fwd_b  out  2 each  ALU operand mux selects (00 regfile, 01 EX/MEM, 10 MEM/WB).
REQ-013 Port: stall_if, stall_id, flush_ex  out  1 each  PC hold, IF/ID hold, ID/EX bubble.
REQ-014 Port: md_busy  out  1  mult/div unit occupied.

Function
REQ-015 fwd_a SHALL be 01 when mem_reg_write, mem_rd!=0 and mem_rd==ex_rs; else 10 when wb_reg_write, wb_rd!=0 and wb_rd==ex_rs; else 00.
REQ-016 fwd_b SHALL follow REQ-015 using ex_rt; EX/MEM has priority over MEM/WB; code 11 SHALL never be driven.
REQ-017 Load-use stall SHALL assert combinationally when ex_mem_read, ex_rd!=0 and ex_rd equals id_rs or id_rt.
REQ-018 A 6-bit busy counter SHALL load MULT_CYCLES (ex_md_div=0) or DIV_CYCLES (ex_md_div=1) at a rising edge where ex_md_start=1 and counter==0.
REQ-019 Counter SHALL decrement by 1 each edge while nonzero, saturating at 0; md_busy SHALL equal (counter!=0), registered-derived, no combinational path from ex_md_start.
REQ-020 ex_md_start while counter!=0 SHALL be ignored (no reload, no restart).
REQ-021 MD stall SHALL assert when id_md_use and md_busy.
REQ-022 stall_if, stall_id and flush_ex SHALL each equal (load-use stall OR MD stall OR RAW stall per REQ-027).
REQ-023 Counter value 1 with id_md_use SHALL still stall; ID proceeds the cycle counter reads 0.

Reset
REQ-024 rst_n low SHALL clear the counter immediately, regardless of clk, forcing md_busy=0.
REQ-025 Reset asserted mid-division SHALL abandon the operation; no stall SHALL persist after release.
REQ-026 With all inputs 0, outputs SHALL be fwd_a=fwd_b=00, stall_if=stall_id=flush_ex=0, md_busy=0.

Configuration
REQ-027 Macro HAZARD_FORWARDING_EN defined: forwarding per REQ-015/016; undefined: fwd_a=fwd_b=00 constant and RAW stall SHALL assert when id_rs or id_rt (nonzero) matches ex_rd with ex_reg_write or mem_rd with mem_reg_write (WB covered by write-first regfile).
REQ-028 Load-use and MD stall logic SHALL be present in both builds.

Structure
REQ-029 Shared package hazard_pkg SHALL hold FWD_REG=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10 and default MULT/DIV cycle constants.
REQ-030 Busy counter SHALL be sub-module md_busy_counter (clk, rst_n, start, div, busy); forwarding/stall compare logic stays in hazard_ctrl.

Verification
REQ-031 mem_reg_write=1, mem_rd=5, wb_reg_write=1, wb_rd=5, ex_rs=5 -> fwd_a=01; mem_reg_write=0 -> fwd_a=10; ex_rs=0 with rd=0 -> fwd_a=00.
REQ-032 ex_mem_read=1, ex_rd=8, id_rt=8 -> stall_if=stall_id=flush_ex=1 one cycle; ex_rd=0 -> no stall.
REQ-033 ex_md_start=1, ex_md_div=0 at edge t -> md_busy=1 for edges t+1..t+4, 0 at t+5; id_md_use=1 throughout -> stall exactly those 4 cycles.
REQ-034 Div start at t, second start at t+3 -> md_busy for exactly 32 cycles from t+1, no reload.
REQ-035 Div start, rst_n pulsed low at t+10 between edges -> md_busy=0 immediately, stays 0 after release.
REQ-036 Build without HAZARD_FORWARDING_EN: ex_reg_write=1, ex_rd=3, id_rs=3 -> stall=1, fwd_a=fwd_b=00.
